// File: rtl/fifo_serializer.sv
// -----------------------------------------------------------------------------
// fifo_serializer
//
// Pulls words from a show-ahead-less FIFO (read data valid one cycle after
// the pop strobe) and shifts them out one bit at a time over a valid/ready
// serial port.
//
//   IDLE  -> waits for a non-empty FIFO, pops combinationally
//   FETCH -> captures fifo_data into the shift register
//   SHIFT -> presents one bit per cycle, advancing only on handshake
//   PAR   -> (optional) presents the even-parity bit of the word
//
// Optional feature macro: FIFO_SERIALIZER_PARITY_EN
//   When defined, each word is followed by one even-parity bit and ser_last
//   marks the parity bit. When undefined, each word is exactly DATA_WIDTH bits.
// -----------------------------------------------------------------------------
module fifo_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  rdclk,
    input  logic                  rd_rst,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    output logic                  ser_data,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  ser_last,
    output logic                  busy,
    output logic [15:0]           word_cnt
);

    // Bit counter just wide enough to index every bit of a word.
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

`ifdef FIFO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_PAR   = 2'd3
    } state_t;

    // Even parity of a word: XOR of all bits, so word plus parity has an
    // even number of ones.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
        even_parity = ^word;
    endfunction
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2
    } state_t;
`endif

    // Next shift-register value after one bit has been consumed.
    function automatic logic [DATA_WIDTH-1:0] shift_once(input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {word[DATA_WIDTH-2:0], 1'b0};
        end else begin
            res = {1'b0, word[DATA_WIDTH-1:1]};
        end
        shift_once = res;
    endfunction

    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [CNT_W-1:0]      bitcnt_q,   bitcnt_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic                  pop_s;
`ifdef FIFO_SERIALIZER_PARITY_EN
    logic                  par_q,      par_d;
`endif

    // Handshake on the serial port this cycle.
    logic                  accept_s;
    assign accept_s = ser_valid & ser_ready;

    // State, datapath and counter registers with asynchronous clear.
    always_ff @(posedge rdclk or negedge rd_rst) begin
        if (!rd_rst) begin
            state_q    <= S_IDLE;
            shift_q    <= {DATA_WIDTH{1'b0}};
            bitcnt_q   <= {CNT_W{1'b0}};
            word_cnt_q <= 16'd0;
`ifdef FIFO_SERIALIZER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            word_cnt_q <= word_cnt_d;
`ifdef FIFO_SERIALIZER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state logic: fetch, shift on handshake, close out the word and
    // decide between back-to-back fetch and returning to IDLE.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        word_cnt_d = word_cnt_q;
        pop_s      = 1'b0;
`ifdef FIFO_SERIALIZER_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Pop only when the FIFO reports data; data arrives next cycle.
                if (!fifo_empty) begin
                    pop_s   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                shift_d  = fifo_data;
                bitcnt_d = {CNT_W{1'b0}};
`ifdef FIFO_SERIALIZER_PARITY_EN
                par_d    = even_parity(fifo_data);
`endif
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                if (accept_s) begin
                    if (bitcnt_q == LAST_IDX) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
                        // Data bits done; the parity bit closes the word.
                        shift_d = shift_once(shift_q);
                        state_d = S_PAR;
`else
                        // Word complete: count it and fetch the next one
                        // straight away if the FIFO has data.
                        shift_d    = shift_once(shift_q);
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (!fifo_empty) begin
                            pop_s   = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_IDLE;
                        end
`endif
                    end else begin
                        shift_d  = shift_once(shift_q);
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end else begin
                    // Stalled by the sink: hold everything.
                    state_d = S_SHIFT;
                end
            end
`ifdef FIFO_SERIALIZER_PARITY_EN
            S_PAR: begin
                if (accept_s) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (!fifo_empty) begin
                        pop_s   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_PAR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Serial port decode from registered state; data forced low when not valid.
    always_comb begin
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_last  = 1'b0;
        case (state_q)
            S_SHIFT: begin
                ser_valid = 1'b1;
                if (MSB_FIRST) begin
                    ser_data = shift_q[DATA_WIDTH-1];
                end else begin
                    ser_data = shift_q[0];
                end
`ifdef FIFO_SERIALIZER_PARITY_EN
                ser_last = 1'b0;
`else
                ser_last = (bitcnt_q == LAST_IDX);
`endif
            end
`ifdef FIFO_SERIALIZER_PARITY_EN
            S_PAR: begin
                ser_valid = 1'b1;
                ser_data  = par_q;
                ser_last  = 1'b1;
            end
`endif
            default: begin
                ser_valid = 1'b0;
                ser_data  = 1'b0;
                ser_last  = 1'b0;
            end
        endcase
    end

    assign fifo_pop = pop_s;
    assign busy     = (state_q != S_IDLE);
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_serializer
//
// Directed stimulus against a small FIFO model. Each pushed word queues its
// expected serial bits (data, last) in a scoreboard; an independent monitor
// pops and compares on every accepted serial handshake. Honours
// FIFO_SERIALIZER_PARITY_EN for the expected bit stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_serializer;

    logic        rdclk = 1'b0;
    logic        rd_rst;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic        ser_last;
    logic        busy;
    logic [15:0] word_cnt;

    fifo_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .rdclk      (rdclk),
        .rd_rst     (rd_rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_last   (ser_last),
        .busy       (busy),
        .word_cnt   (word_cnt)
    );

    always #5 rdclk = ~rdclk;

    // FIFO model: read data appears one cycle after the pop strobe.
    logic [7:0] mem [0:31];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rdclk) begin
        if (fifo_pop) begin
            fifo_data <= mem[rd_ptr % 32];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int         checks  = 0;
    int         errors  = 0;
    logic [1:0] exp_q[$];          // {data, last}
    int         acc_cnt = 0;
    int         pop_cnt = 0;
    logic       prev_stall = 1'b0;
    logic       prev_data  = 1'b0;
    logic [3:0] pat = 4'b1001;     // ready pattern 1,0,0,1 (index 0 first)
    int         exp_cnt = 0;

    // Monitor: protocol checks and scoreboard comparison on each handshake.
    always @(negedge rdclk) begin : monitor
        logic [1:0] e;
        if (rd_rst) begin
            if (fifo_pop) begin
                pop_cnt++;
                checks++;
                if (fifo_empty) begin
                    errors++;
                    $display("FAIL pop_when_empty actual pop=1 empty=1 required pop=0");
                end
            end
            if (!ser_valid) begin
                checks++;
                if (ser_data !== 1'b0) begin
                    errors++;
                    $display("FAIL data_low_when_invalid actual=%b required=0", ser_data);
                end
            end
            if (prev_stall && ser_valid) begin
                checks++;
                if (ser_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold actual=%b required=%b", ser_data, prev_data);
                end
            end
            if (ser_valid && ser_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit actual data=%b last=%b required none", ser_data, ser_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({ser_data, ser_last} !== e) begin
                        errors++;
                        $display("FAIL serial_bit actual data=%b last=%b required data=%b last=%b",
                                 ser_data, ser_last, e[1], e[0]);
                    end
                end
                acc_cnt++;
            end
            prev_stall = ser_valid && !ser_ready;
            prev_data  = ser_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Put a word in the FIFO and queue its expected serial bits.
    task automatic push_word(input logic [7:0] w);
        @(posedge rdclk);
        #1;
        mem[wr_ptr % 32] = w;
        for (int i = 0; i < 8; i++) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
            exp_q.push_back({w[7-i], 1'b0});
`else
            exp_q.push_back({w[7-i], (i == 7) ? 1'b1 : 1'b0});
`endif
        end
`ifdef FIFO_SERIALIZER_PARITY_EN
        exp_q.push_back({^w, 1'b1});
`endif
        wr_ptr = wr_ptr + 1;
    endtask

    // Run until the DUT is idle with nothing pending; mode 1 toggles ready.
    task automatic wait_done(input int mode, input string name);
        int  k;
        bit  done;
        k    = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge rdclk);
            #1;
            if (mode == 1) begin
                ser_ready = pat[k % 4];
                k++;
            end
            if (!busy && fifo_empty && exp_q.size() == 0) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
        ser_ready = 1'b1;
    endtask

    // Wait (bounded) for the handshake of a last bit; true if seen.
    task automatic wait_last(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge rdclk);
            if (ser_valid && ser_ready && ser_last) seen = 1'b1;
        end
    endtask

    initial begin : stim
        bit seen;
        int base;
        rd_rst    = 1'b0;
        ser_ready = 1'b1;
        repeat (3) @(posedge rdclk);
        #1;
        check("reset_outputs", {26'd0, fifo_pop, ser_valid, ser_data, ser_last, busy, 1'b0}, 32'd0);
        check("reset_word_cnt", {16'd0, word_cnt}, 32'd0);
        rd_rst = 1'b1;

        // Empty FIFO: nothing moves.
        for (int c = 0; c < 50; c++) begin
            @(negedge rdclk);
            check("empty_idle", {29'd0, fifo_pop, ser_valid, busy}, 32'd0);
        end

        // Single word 0xA5: pop, one FETCH bubble, first bit two cycles after pop.
        push_word(8'hA5);
        @(negedge rdclk);
        check("a5_pop", {31'd0, fifo_pop}, 32'd1);
        @(negedge rdclk);
        check("a5_fetch", {30'd0, ser_valid, fifo_pop}, 32'd0);
        @(negedge rdclk);
        check("a5_first_valid", {30'd0, ser_valid, ser_data}, 32'd3);
        wait_done(0, "a5_done");
        exp_cnt = 1;
        check("a5_word_cnt", {16'd0, word_cnt}, exp_cnt);
        check("a5_idle", {31'd0, busy}, 32'd0);

        // Back-to-back 0x01, 0x80: pop alongside the last bit, one bubble.
        push_word(8'h01);
        push_word(8'h80);
        wait_last(seen);
        check("b2b_last_seen", {31'd0, seen}, 32'd1);
        check("b2b_pop_on_last", {31'd0, fifo_pop}, 32'd1);
        @(negedge rdclk);
        check("b2b_bubble", {31'd0, ser_valid}, 32'd0);
        @(negedge rdclk);
        check("b2b_resume", {31'd0, ser_valid}, 32'd1);
        wait_done(0, "b2b_done");
        exp_cnt = 3;
        check("b2b_word_cnt", {16'd0, word_cnt}, exp_cnt);

        // Backpressure on 0x3C.
        push_word(8'h3C);
        wait_done(1, "bp_done");
        exp_cnt = 4;
        check("bp_word_cnt", {16'd0, word_cnt}, exp_cnt);

        // 0x07: count does not move before the word-closing bit is accepted.
        push_word(8'h07);
        wait_last(seen);
        check("w07_last_seen", {31'd0, seen}, 32'd1);
        check("w07_cnt_before", {16'd0, word_cnt}, exp_cnt);
        wait_done(0, "w07_done");
        exp_cnt = 5;
        check("w07_word_cnt", {16'd0, word_cnt}, exp_cnt);

        // Mid-word reset after three bits of 0xFF, then 0x0F must go intact.
        push_word(8'hFF);
        base = acc_cnt;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge rdclk);
            #1;
            if (acc_cnt >= base + 3) seen = 1'b1;
        end
        check("rst_three_bits", {31'd0, seen}, 32'd1);
        rd_rst = 1'b0;
        #1;
        check("rst_outputs", {27'd0, fifo_pop, ser_valid, ser_data, ser_last, busy}, 32'd0);
        check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(posedge rdclk);
        #1;
        rd_rst = 1'b1;
        push_word(8'h0F);
        wait_done(0, "post_rst_done");
        exp_cnt = 1;
        check("post_rst_word_cnt", {16'd0, word_cnt}, exp_cnt);

        // Exactly one pop per word pushed.
        check("pop_count", pop_cnt, wr_ptr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
